// File: rtl/bsg_vanilla_pkg.sv
// ----------------------------------------------------------------------------
// bsg_vanilla_pkg
//   Shared types for the vanilla core. This slice holds the integer-divide
//   operation encoding that the decoder emits (idiv_op_e) and the state
//   encoding of the iterative divider controller (idiv_state_e).
//   No ports; imported by vanilla_idiv_seq and its testbench.
// ----------------------------------------------------------------------------
package bsg_vanilla_pkg;

    // Operation selected by the decoder's idiv_op field.
    typedef enum logic [1:0] {
        eDIV  = 2'b00,
        eDIVU = 2'b01,
        eREM  = 2'b10,
        eREMU = 2'b11
    } idiv_op_e;

    // Divider controller states.
    typedef enum logic [1:0] {
        eIDIV_IDLE = 2'b00,
        eIDIV_CALC = 2'b01,
        eIDIV_DONE = 2'b10
    } idiv_state_e;

    // True for the ops that interpret operands as two's complement.
    function automatic logic idiv_is_signed(idiv_op_e op);
        return (op == eDIV) || (op == eREM);
    endfunction

    // True for the ops that return the remainder rather than the quotient.
    function automatic logic idiv_is_rem(idiv_op_e op);
        return (op == eREM) || (op == eREMU);
    endfunction

endpackage

// File: rtl/vanilla_idiv_step.sv
// ----------------------------------------------------------------------------
// vanilla_idiv_step
//   One iteration of an unsigned restoring divider, purely combinational.
//   {rem, quo} is shifted left by one, the divisor is trial-subtracted from
//   the widened partial remainder, and the new quotient bit is 1 when the
//   subtraction does not go negative (the remainder is then replaced by the
//   difference, otherwise the shifted value is kept).
//
//   Ports:
//     rem_i     in  data_width_p  partial remainder (always < divisor_i)
//     quo_i     in  data_width_p  dividend bits still to shift in / quotient
//     divisor_i in  data_width_p  unsigned divisor (non-zero)
//     rem_o     out data_width_p  next partial remainder
//     quo_o     out data_width_p  next {dividend, quotient} word
// ----------------------------------------------------------------------------
module vanilla_idiv_step #(
    parameter int data_width_p = 32
) (
    input  logic [data_width_p-1:0] rem_i,
    input  logic [data_width_p-1:0] quo_i,
    input  logic [data_width_p-1:0] divisor_i,
    output logic [data_width_p-1:0] rem_o,
    output logic [data_width_p-1:0] quo_o
);

    // The shifted remainder needs one extra bit: with a divisor near 2^W the
    // value 2*rem+1 overflows W bits before the subtraction brings it back.
    logic [data_width_p:0]   rem_shift;
    logic [data_width_p-1:0] diff;
    logic                    fits;

    assign rem_shift = {rem_i, quo_i[data_width_p-1]};
    assign fits      = (rem_shift >= {1'b0, divisor_i});
    // When fits, the true difference is below the divisor, so the low W bits
    // of the wrapped subtraction are exact.
    assign diff      = rem_shift[data_width_p-1:0] - divisor_i;

    assign rem_o = fits ? diff : rem_shift[data_width_p-1:0];
    assign quo_o = {quo_i[data_width_p-2:0], fits};

endmodule

// File: rtl/vanilla_idiv_seq.sv
// ----------------------------------------------------------------------------
// vanilla_idiv_seq
//   Iterative integer divide unit (DIV, DIVU, REM, REMU) for the vanilla core.
//   One request at a time; one quotient bit per cycle over data_width_p
//   cycles. Divide-by-zero and signed overflow bypass the iteration and are
//   answered one cycle after accept. The result is held until the writeback
//   arbiter takes it with yumi_i.
//
//   Ports:
//     clk_i       in   1                 clock
//     reset_i     in   1                 synchronous, active-high reset
//     v_i         in   1                 request valid
//     ready_and_o out  1                 unit can accept a request
//     op_i        in   idiv_op_e         eDIV / eDIVU / eREM / eREMU
//     rs1_i       in   data_width_p      dividend
//     rs2_i       in   data_width_p      divisor
//     rd_i        in   reg_addr_width_p  destination register
//     v_o         out  1                 result valid
//     result_o    out  data_width_p      quotient or remainder
//     rd_o        out  reg_addr_width_p  destination of result_o
//     yumi_i      in   1                 consumer takes result (only if v_o)
// ----------------------------------------------------------------------------
module vanilla_idiv_seq
    import bsg_vanilla_pkg::*;
#(
    parameter int data_width_p     = 32,
    parameter int reg_addr_width_p = 5
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        v_i,
    output logic                        ready_and_o,
    input  idiv_op_e                    op_i,
    input  logic [data_width_p-1:0]     rs1_i,
    input  logic [data_width_p-1:0]     rs2_i,
    input  logic [reg_addr_width_p-1:0] rd_i,
    output logic                        v_o,
    output logic [data_width_p-1:0]     result_o,
    output logic [reg_addr_width_p-1:0] rd_o,
    input  logic                        yumi_i
);

    localparam int cnt_width_lp = $clog2(data_width_p + 1);
    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(data_width_p - 1);
    localparam logic [data_width_p-1:0] min_neg_lp  = {1'b1, {(data_width_p-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    idiv_state_e                 state_q,    state_d;
    logic [cnt_width_lp-1:0]     cnt_q,      cnt_d;
    logic [data_width_p-1:0]     rem_q,      rem_d;
    logic [data_width_p-1:0]     quo_q,      quo_d;
    logic [data_width_p-1:0]     divisor_q,  divisor_d;
    logic                        is_rem_q,   is_rem_d;
    logic                        neg_quo_q,  neg_quo_d;
    logic                        neg_rem_q,  neg_rem_d;
    logic [data_width_p-1:0]     result_q,   result_d;
    logic [reg_addr_width_p-1:0] rd_q,       rd_d;

    // ------------------------------------------------------------------
    // Operand preparation and special-case detection at accept
    // ------------------------------------------------------------------
    logic                    op_signed;
    logic                    op_rem;
    logic                    rs1_neg;
    logic                    rs2_neg;
    logic [data_width_p-1:0] rs1_abs;
    logic [data_width_p-1:0] rs2_abs;
    logic                    div_by_zero;
    logic                    overflow;
    logic [data_width_p-1:0] special_result;

    assign op_signed   = idiv_is_signed(op_i);
    assign op_rem      = idiv_is_rem(op_i);
    assign rs1_neg     = op_signed & rs1_i[data_width_p-1];
    assign rs2_neg     = op_signed & rs2_i[data_width_p-1];
    assign rs1_abs     = rs1_neg ? -rs1_i : rs1_i;
    assign rs2_abs     = rs2_neg ? -rs2_i : rs2_i;
    assign div_by_zero = (rs2_i == '0);
    assign overflow    = op_signed && (rs1_i == min_neg_lp) && (rs2_i == '1);

    // Overflow: quotient is the dividend itself (MIN), remainder is zero.
    always_comb begin
        if (div_by_zero) begin
            special_result = op_rem ? rs1_i : '1;
        end else begin
            special_result = op_rem ? '0 : rs1_i;
        end
    end

    // ------------------------------------------------------------------
    // Datapath step and sign fixup
    // ------------------------------------------------------------------
    logic [data_width_p-1:0] step_rem;
    logic [data_width_p-1:0] step_quo;
    logic [data_width_p-1:0] final_result;

    vanilla_idiv_step #(
        .data_width_p (data_width_p)
    ) step_u (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    assign final_result = is_rem_q ? (neg_rem_q ? -step_rem : step_rem)
                                   : (neg_quo_q ? -step_quo : step_quo);

    // ------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------
    // NOTE: every signal is given a default before the case so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        divisor_d   = divisor_q;
        is_rem_d    = is_rem_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        result_d    = result_q;
        rd_d        = rd_q;
        ready_and_o = 1'b0;
        v_o         = 1'b0;

        unique case (state_q)
            eIDIV_IDLE: begin
                ready_and_o = 1'b1;
                if (v_i) begin
                    rd_d      = rd_i;
                    is_rem_d  = op_rem;
                    neg_quo_d = rs1_neg ^ rs2_neg;
                    neg_rem_d = rs1_neg;
                    if (div_by_zero || overflow) begin
                        result_d = special_result;
                        state_d  = eIDIV_DONE;
                    end else begin
                        rem_d     = '0;
                        quo_d     = rs1_abs;
                        divisor_d = rs2_abs;
                        cnt_d     = '0;
                        state_d   = eIDIV_CALC;
                    end
                end
            end

            eIDIV_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == last_cnt_lp) begin
                    result_d = final_result;
                    state_d  = eIDIV_DONE;
                end
            end

            eIDIV_DONE: begin
                v_o = 1'b1;
                if (yumi_i) begin
                    state_d = eIDIV_IDLE;
                end
            end

            default: begin
                state_d = eIDIV_IDLE;
            end
        endcase
    end

    assign result_o = result_q;
    assign rd_o     = rd_q;

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the same pre-edge values. The datapath registers are
    // reset too, which keeps result_o/rd_o at a defined 0 out of reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= eIDIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
        end
    end

    // The consumer may only take a result that is being offered.
    yumi_needs_valid_a: assert property (
        @(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o
    );

endmodule

// File: tb/tb_vanilla_idiv_seq.sv
// ----------------------------------------------------------------------------
// tb_vanilla_idiv_seq
//   Directed bench for vanilla_idiv_seq. The driver pushes the hand-computed
//   {result, rd} of each request into a queue; an independent monitor pops
//   and compares whenever a result is handed over (v_o & yumi_i). The driver
//   itself checks latency and ready/valid handshake behaviour.
// ----------------------------------------------------------------------------
module tb_vanilla_idiv_seq;
    import bsg_vanilla_pkg::*;

    localparam int W = 32;
    localparam int R = 5;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          v_i;
    logic          ready_and_o;
    idiv_op_e      op_i;
    logic [W-1:0]  rs1_i;
    logic [W-1:0]  rs2_i;
    logic [R-1:0]  rd_i;
    logic          v_o;
    logic [W-1:0]  result_o;
    logic [R-1:0]  rd_o;
    logic          yumi_i;

    always #5 clk_i = ~clk_i;

    vanilla_idiv_seq #(
        .data_width_p     (W),
        .reg_addr_width_p (R)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .v_i         (v_i),
        .ready_and_o (ready_and_o),
        .op_i        (op_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .rd_i        (rd_i),
        .v_o         (v_o),
        .result_o    (result_o),
        .rd_o        (rd_o),
        .yumi_i      (yumi_i)
    );

    typedef struct packed {
        logic [W-1:0] result;
        logic [R-1:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare each handed-over result against the scoreboard.
    always @(negedge clk_i) begin
        if (!reset_i && v_o && yumi_i) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: got 0x%08h rd %0d, nothing expected", result_o, rd_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", result_o, e.result);
                check("rd", 32'(rd_o), 32'(e.rd));
            end
        end
    end

    // All driving happens 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Present a request in the current cycle (ready must already be high).
    task automatic issue(input idiv_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [R-1:0] rd, input logic [W-1:0] exp_res);
        exp_t e;
        v_i   = 1'b1;
        op_i  = op;
        rs1_i = a;
        rs2_i = b;
        rd_i  = rd;
        e.result = exp_res;
        e.rd     = rd;
        exp_q.push_back(e);
    endtask

    // Count cycles from the accept edge until v_o (cycle 1 is the first one
    // after accept), bounded.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!v_o && lat < 100) begin
            next_cycle();
            lat++;
        end
    endtask

    task automatic take_result();
        yumi_i = 1'b1;
        next_cycle();
        yumi_i = 1'b0;
        check("ready_after_yumi", 32'(ready_and_o), 32'd1);
        check("v_o_after_yumi", 32'(v_o), 32'd0);
    endtask

    task automatic do_op(input idiv_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [R-1:0] rd, input logic [W-1:0] exp_res, input int exp_lat);
        int n;
        int lat;
        n = 0;
        while (!ready_and_o && n < 50) begin
            next_cycle();
            n++;
        end
        check("ready_before_accept", 32'(ready_and_o), 32'd1);
        issue(op, a, b, rd, exp_res);
        next_cycle();
        v_i = 1'b0;
        wait_valid(lat);
        check("latency", 32'(lat), 32'(exp_lat));
        if (v_o) take_result();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        reset_i = 1'b1;
        v_i     = 1'b0;
        yumi_i  = 1'b0;
        op_i    = eDIV;
        rs1_i   = '0;
        rs2_i   = '0;
        rd_i    = '0;
        repeat (3) next_cycle();
        check("reset_ready", 32'(ready_and_o), 32'd1);
        check("reset_v_o", 32'(v_o), 32'd0);
        check("reset_result", result_o, 32'd0);
        check("reset_rd", 32'(rd_o), 32'd0);
        reset_i = 1'b0;
        next_cycle();

        // Normal iterations.
        do_op(eDIV,  32'd100,        32'd7,          5'd1,  32'd14,         33);
        do_op(eREM,  32'd100,        32'd7,          5'd2,  32'd2,          33);
        do_op(eDIV,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,  33);
        do_op(eREM,  32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFF,  33);
        do_op(eDIVU, 32'hFFFF_FFFF,  32'd1,          5'd5,  32'hFFFF_FFFF,  33);
        do_op(eDIV,  32'd7,          32'hFFFF_FFFE,  5'd6,  32'hFFFF_FFFD,  33);
        do_op(eREM,  32'd7,          32'hFFFF_FFFE,  5'd7,  32'd1,          33);
        do_op(eDIV,  32'h8000_0000,  32'd3,          5'd8,  32'hD555_5556,  33);
        do_op(eREM,  32'h8000_0000,  32'd3,          5'd9,  32'hFFFF_FFFE,  33);
        do_op(eREMU, 32'hFFFF_FFFF,  32'h8000_0000,  5'd10, 32'h7FFF_FFFF,  33);
        do_op(eDIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'd0,          33);

        // Special cases answered without iterating.
        do_op(eREMU, 32'h0000_1234,  32'd0,          5'd12, 32'h0000_1234,  1);
        do_op(eDIV,  32'd5,          32'd0,          5'd13, 32'hFFFF_FFFF,  1);
        do_op(eDIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'h8000_0000,  1);
        do_op(eREM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'd0,          1);

        // Result backpressure with a competing request held on v_i.
        issue(eDIV, 32'd100, 32'd7, 5'd3, 32'd14);
        next_cycle();
        v_i = 1'b0;
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd33);
        issue(eDIVU, 32'd50, 32'd5, 5'd9, 32'd10);
        repeat (10) begin
            next_cycle();
            check("bp_v_o", 32'(v_o), 32'd1);
            check("bp_result", result_o, 32'd14);
            check("bp_rd", 32'(rd_o), 32'd3);
            check("bp_ready", 32'(ready_and_o), 32'd0);
        end
        yumi_i = 1'b1;
        next_cycle();
        yumi_i = 1'b0;
        check("bp_ready_after_yumi", 32'(ready_and_o), 32'd1);
        check("bp_v_o_after_yumi", 32'(v_o), 32'd0);
        next_cycle();
        v_i = 1'b0;
        check("bp_accepted", 32'(ready_and_o), 32'd0);
        wait_valid(lat);
        check("bp_second_latency", 32'(lat), 32'd33);
        if (v_o) take_result();

        // Reset in the middle of an iteration drops the operation.
        issue(eDIVU, 32'd1000, 32'd3, 5'd20, 32'd333);
        void'(exp_q.pop_back());
        next_cycle();
        v_i = 1'b0;
        repeat (14) next_cycle();
        reset_i = 1'b1;
        next_cycle();
        reset_i = 1'b0;
        check("midreset_v_o", 32'(v_o), 32'd0);
        check("midreset_ready", 32'(ready_and_o), 32'd1);
        do_op(eDIVU, 32'd1000, 32'd3, 5'd21, 32'd333, 33);

        repeat (3) next_cycle();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
